// File: rtl/page_ram_arbiter.sv
// page_ram_arbiter
//   Owns the single-port page-parameter RAM (2^ADDR_W x DATA_W) and shares
//   it between two requesters with round-robin arbitration. After reset an
//   optional clear pass writes INIT_VALUE to every entry before RUN.
//
// Ports
//   hw_clk          sole clock, rising edge
//   rst             synchronous reset, active-high
//   ready           high in RUN (low during reset and the clear pass)
//   reqN/weN        request and access type (1 = write, 0 = read) for port N
//   addrN/wdataN    address and write data for port N
//   gntN            combinational grant; the access executes on the edge
//                   where reqN and gntN are both high
//   rdataN/rvalidN  read data (held until the next read on that port) and
//                   its one-cycle valid pulse, one cycle after the grant edge
module page_ram_arbiter #(
  parameter int                ADDR_W         = 8,
  parameter int                DATA_W         = 8,
  parameter logic [DATA_W-1:0] INIT_VALUE     = 8'hFF,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic              hw_clk,
  input  logic              rst,
  output logic              ready,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic [DATA_W-1:0] rdata0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid1
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_addr;
  logic              last_gnt;

  logic              ram_we_p0;
  logic              ram_re_p0;
  logic [ADDR_W-1:0] ram_addr_p0;
  logic [DATA_W-1:0] ram_wdata_p0;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q_p1;
  logic              vld0_p1;
  logic              vld1_p1;
  logic [DATA_W-1:0] hold0_p1;
  logic [DATA_W-1:0] hold1_p1;

  // Control: state, clear address, round-robin history, read valids
  always_ff @(posedge hw_clk) begin
    if (rst) begin
      state    <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_addr <= '0;
      last_gnt <= 1'b1;
      vld0_p1  <= 1'b0;
      vld1_p1  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) begin
        clr_addr <= clr_addr + 1'b1;
      end
      if (gnt0) begin
        last_gnt <= 1'b0;
      end else if (gnt1) begin
        last_gnt <= 1'b1;
      end
      vld0_p1 <= gnt0 & ~we0;
      vld1_p1 <= gnt1 & ~we1;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    case (state)
      ST_CLEAR: begin
        if (clr_addr == {ADDR_W{1'b1}}) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // last_gnt = 1 means port 1 was served last, so port 0 wins a tie.
        if (!rst) begin
          gnt0 = req0 & (~req1 | last_gnt);
          gnt1 = req1 & (~req0 | ~last_gnt);
        end
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  assign ready = (state == ST_RUN) & ~rst;

  // Stage p0: single RAM port shared by the clear sequencer and the grantee
  always_comb begin
    ram_we_p0    = 1'b0;
    ram_re_p0    = 1'b0;
    ram_addr_p0  = clr_addr;
    ram_wdata_p0 = INIT_VALUE;
    if (state == ST_CLEAR) begin
      ram_we_p0 = ~rst;
    end else if (gnt0) begin
      ram_addr_p0  = addr0;
      ram_wdata_p0 = wdata0;
      ram_we_p0    = we0;
      ram_re_p0    = ~we0;
    end else if (gnt1) begin
      ram_addr_p0  = addr1;
      ram_wdata_p0 = wdata1;
      ram_we_p0    = we1;
      ram_re_p0    = ~we1;
    end
  end

  always_ff @(posedge hw_clk) begin
    if (ram_we_p0) begin
      mem[ram_addr_p0] <= ram_wdata_p0;
    end
    if (ram_re_p0) begin
      ram_q_p1 <= mem[ram_addr_p0];
    end
  end

  // Stage p1: shared RAM output steered to the port that issued the read.
  // A reset arriving in the cycle after the grant suppresses the pulse.
  assign rvalid0 = vld0_p1 & ~rst;
  assign rvalid1 = vld1_p1 & ~rst;

  always_ff @(posedge hw_clk) begin
    if (rst) begin
      hold0_p1 <= '0;
      hold1_p1 <= '0;
    end else begin
      if (rvalid0) begin
        hold0_p1 <= ram_q_p1;
      end
      if (rvalid1) begin
        hold1_p1 <= ram_q_p1;
      end
    end
  end

  assign rdata0 = rvalid0 ? ram_q_p1 : hold0_p1;
  assign rdata1 = rvalid1 ? ram_q_p1 : hold1_p1;

endmodule

// File: doc/page_ram_arbiter.md
Name: page_ram_arbiter

Overview:
- Owns the single-port page-parameter RAM (2^ADDR_W x DATA_W, block-RAM inferred) and shares it between two requesters using round-robin arbitration.
- After reset, sequences a clear pass that fills every entry with INIT_VALUE, so RAM contents are defined without relying on initial blocks.
- Sits between the page_param consumers/producers and the RAM; no other block touches the RAM directly.

Parameters:
- ADDR_W, 8, address width; depth = 2^ADDR_W.
- DATA_W, 8, data width.
- INIT_VALUE, 8'hFF, value written to every entry during the clear pass.
- CLEAR_ON_RESET, 1, 1 = run the clear pass after reset; 0 = go straight to RUN with RAM contents undefined.

Ports:
- hw_clk  in  1  sole clock, all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- ready  out  1  high in RUN state; low during reset and the clear pass.
- req0  in  1  port 0 access request; held until granted.
- we0  in  1  port 0 access type: 1 = write, 0 = read.
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- gnt0  out  1  port 0 grant (combinational); the access executes on the edge where req0 and gnt0 are both high.
- rdata0  out  DATA_W  port 0 read data.
- rvalid0  out  1  one-cycle pulse: rdata0 is valid.
- req1, we1, addr1, wdata1, gnt1, rdata1, rvalid1: same as port 0, for port 1.

Behaviour:
- Clock/reset: one clock, hw_clk. Reset is synchronous and active-high on rst.
- Reset values: state = CLEAR (or RUN if CLEAR_ON_RESET=0); clr_addr = 0; last_gnt = 1 (port 0 wins the first conflict); ready = 0; rvalid0/1 = 0; rdata0/1 = 0. RAM contents are not reset.
- State CLEAR:
  - Each cycle writes INIT_VALUE to clr_addr, then increments clr_addr.
  - After the write to address 2^ADDR_W-1 (exactly 2^ADDR_W cycles), the next state is RUN.
  - gnt0/gnt1 are forced to 0; requests are ignored and stay pending.
- State RUN:
  - ready = 1.
  - gnt0 = req0 & (!req1 | last_gnt==1).
  - gnt1 = req1 & (!req0 | last_gnt==0).
  - At most one grant per cycle.
  - On each granted edge: last_gnt updates to the granted port index; it is unchanged on cycles with no grant.
  - A lone requester is granted every cycle, so back-to-back accesses run at 1 per cycle.
  - With both requesting continuously, grants alternate 0,1,0,1...
- Write: RAM[addr] <= wdata on the grant edge. No rvalid is generated.
- Read:
  - RAM is registered on the grant edge.
  - rdata_n and rvalid_n are asserted on the following cycle. Read latency is 1 cycle from the grant edge.
  - rdata_n holds its value until the next read on that port.
  - rvalid pulses for exactly one cycle per granted read.
- Read-after-write to the same address on the next cycle (either port) returns the new data.
- The RAM is single port, so no same-cycle collision is possible.
- A requester drops req only after the grant edge. Dropping req before the grant withdraws the request with no side effects.
- Address width: the full address range is legal. No wrap handling is needed beyond ADDR_W truncation of clr_addr.
- rst asserted mid-clear: the clear pass restarts from address 0.
- rst asserted mid-RUN: an in-flight read's rvalid is suppressed (rvalid forced to 0 the cycle after rst). The clear pass reruns when CLEAR_ON_RESET=1.

Test Plan:
- Reset, CLEAR_ON_RESET=1, DEPTH=256 -> ready rises exactly 256 cycles after rst deasserts. Reading addr 0x00, 0x03 and 0xFF returns 0xFF.
- Port 0 writes 0x5A to addr 3; next cycle port 0 reads addr 3 -> gnt0 high both cycles; rvalid0 pulses one cycle later with rdata0=0x5A; rvalid1 stays 0.
- req0 and req1 both held high for 6 reads (port 0 to addr 1, port 1 to addr 2) -> grant order 0,1,0,1,0,1; each rvalid pulses 3 times with correct data; no cycle has both grants high.
- Requests asserted during CLEAR -> no grant until ready=1; the pending request is granted on the first RUN cycle and reads INIT_VALUE.
- rst pulsed 100 cycles into CLEAR -> clear restarts; ready rises 256 cycles after the second deassertion.
- rst pulsed in the cycle after a granted read -> no rvalid pulse.
- Port 1 alone issues writes to addresses 0..15 on consecutive cycles, then reads them back -> 1 access per cycle; read data equals written data.
